// File: rtl/midi_pkg.sv
// midi_pkg: shared MIDI definitions for the transmit (and receive) path.
//   - status-class constants
//   - MIDI_BAUD nominal bit rate
//   - transmitter FSM state encoding
//   - midi_len(): message length from a status byte
//   - midi_is_channel(): status byte belongs to a channel-voice message
package midi_pkg;

  localparam int MIDI_BAUD = 31250;

  localparam logic [7:0] NOTE_OFF     = 8'h80;
  localparam logic [7:0] NOTE_ON      = 8'h90;
  localparam logic [7:0] PROG_CHG     = 8'hC0;
  localparam logic [7:0] CHAN_PRESS   = 8'hD0;
  localparam logic [7:0] SYS_COMMON   = 8'hF0;
  localparam logic [7:0] REALTIME_MIN = 8'hF8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Channel-voice statuses occupy 0x80..0xEF.
  function automatic logic midi_is_channel(input logic [7:0] status);
    midi_is_channel = (status >= NOTE_OFF) && (status < SYS_COMMON);
  endfunction

  // Number of bytes on the wire for a message with this status, counting
  // the status byte itself. 0 means the status is invalid (bit 7 clear).
  // System common / SysEx statuses send the status byte only.
  function automatic logic [1:0] midi_len(input logic [7:0] status);
    if (!status[7]) begin
      midi_len = 2'd0;
    end else if (status >= REALTIME_MIN) begin
      midi_len = 2'd1;
    end else if (status >= SYS_COMMON) begin
      midi_len = 2'd1;
    end else if ((status[7:4] == PROG_CHG[7:4]) || (status[7:4] == CHAN_PRESS[7:4])) begin
      midi_len = 2'd2;
    end else begin
      midi_len = 2'd3;
    end
  endfunction

endpackage

// File: rtl/midi_tx_baud.sv
// midi_tx_baud: bit-period counter.
//   clk_i   system clock
//   rst_i   asynchronous active-high reset
//   en_i    count enable; while low the counter is held at 0 so the first
//           enabled cycle always starts a full bit period
//   tick_o  high in the last cycle of each BIT_CLKS-cycle bit period
module midi_tx_baud #(
  parameter int BIT_CLKS = 1600
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [10:0] LAST = 11'(BIT_CLKS - 1);

  logic [10:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (cnt_q == LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 11'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/midi_tx.sv
// midi_tx: MIDI UART transmitter, 8N1, LSB first, one message of 1..3 bytes.
//   Clk       system clock
//   Rst_p     asynchronous active-high reset
//   Msg       {status, data1, data2}; data bytes beyond the message length
//             are ignored
//   MsgValid  Msg is valid
//   MsgReady  block can accept a message (high only in IDLE)
//   MIDI_out  serial line, idles high
//   Busy      a frame is in progress
//   Done      one-cycle pulse when a message completes or is discarded
//   DbgState  current FSM state (tx_state_t encoding)
//
// Handshake: a message transfers on the rising edge where MsgValid and
// MsgReady are both high. There is no buffering, so the master must hold
// MsgValid and Msg stable until that edge; Msg is sampled only then.
module midi_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ         = 50000000,
  parameter int BAUD           = MIDI_BAUD,
  parameter int RUNNING_STATUS = 1
) (
  input  logic        Clk,
  input  logic        Rst_p,
  input  logic [23:0] Msg,
  input  logic        MsgValid,
  output logic        MsgReady,
  output logic        MIDI_out,
  output logic        Busy,
  output logic        Done,
  output logic [1:0]  DbgState
);

  localparam int BIT_CLKS = CLK_HZ / BAUD;

  tx_state_t   state_q;
  logic [23:0] msg_q;
  logic [7:0]  sh_q;      // current byte, shifted right as bits go out
  logic [7:0]  last_q;    // last transmitted channel status
  logic [3:0]  bit_q;     // data bit index 0..7
  logic [1:0]  byte_q;    // 0 = status, 1 = data1, 2 = data2
  logic [1:0]  end_q;     // index of the final byte of this message
  logic        line_q;
  logic        ready_q;
  logic        busy_q;
  logic        done_q;
  logic        tick;

  // Byte of a message by position.
  function automatic logic [7:0] byte_sel(input logic [23:0] m, input logic [1:0] idx);
    case (idx)
      2'd0:    byte_sel = m[23:16];
      2'd1:    byte_sel = m[15:8];
      default: byte_sel = m[7:0];
    endcase
  endfunction

  // Decode of the message being offered, used on the accept edge.
  logic [7:0] acc_status;
  logic [1:0] acc_len;
  logic       acc_skip;
  logic [1:0] acc_first;
  logic [7:0] acc_last;

  always_comb begin
    acc_status = Msg[23:16];
    acc_len    = midi_len(acc_status);
    acc_skip   = (RUNNING_STATUS != 0) && midi_is_channel(acc_status) &&
                 (acc_status == last_q);
    acc_first  = acc_skip ? 2'd1 : 2'd0;
    acc_last   = last_q;
    if (RUNNING_STATUS != 0) begin
      if (midi_is_channel(acc_status)) begin
        acc_last = acc_status;
      end else if (acc_status[7] && (acc_status < REALTIME_MIN)) begin
        // system common / SysEx cancels running status
        acc_last = 8'h00;
      end
    end
  end

  midi_tx_baud #(.BIT_CLKS(BIT_CLKS)) u_baud (
    .clk_i  (Clk),
    .rst_i  (Rst_p),
    .en_i   (busy_q),
    .tick_o (tick)
  );

  always_ff @(posedge Clk or posedge Rst_p) begin
    if (Rst_p) begin
      state_q <= ST_IDLE;
      msg_q   <= '0;
      sh_q    <= '0;
      last_q  <= 8'h00;
      bit_q   <= '0;
      byte_q  <= '0;
      end_q   <= '0;
      line_q  <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (MsgValid && ready_q) begin
            msg_q <= Msg;
            if (acc_len == 2'd0) begin
              // invalid status: swallow it, stay ready, report completion
              done_q <= 1'b1;
            end else begin
              state_q <= ST_START;
              line_q  <= 1'b0;
              ready_q <= 1'b0;
              busy_q  <= 1'b1;
              byte_q  <= acc_first;
              end_q   <= acc_len - 2'd1;
              sh_q    <= byte_sel(Msg, acc_first);
              last_q  <= acc_last;
            end
          end
        end
        ST_START: begin
          if (tick) begin
            state_q <= ST_DATA;
            line_q  <= sh_q[0];
            sh_q    <= {1'b0, sh_q[7:1]};
            bit_q   <= 4'd0;
          end
        end
        ST_DATA: begin
          if (tick) begin
            if (bit_q == 4'd7) begin
              state_q <= ST_STOP;
              line_q  <= 1'b1;
            end else begin
              line_q <= sh_q[0];
              sh_q   <= {1'b0, sh_q[7:1]};
              bit_q  <= bit_q + 4'd1;
            end
          end
        end
        ST_STOP: begin
          if (tick) begin
            if (byte_q == end_q) begin
              state_q <= ST_IDLE;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // next byte follows immediately, no idle gap
              state_q <= ST_START;
              line_q  <= 1'b0;
              byte_q  <= byte_q + 2'd1;
              sh_q    <= byte_sel(msg_q, byte_q + 2'd1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign MsgReady = ready_q;
  assign MIDI_out = line_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign DbgState = state_q;

endmodule

// File: tb/tb_midi_tx.sv
// Bench for midi_tx. Two instances: index 0 with running status enabled,
// index 1 with it disabled. A reduced clock rate gives 16 cycles per bit so
// the whole run stays short; all timing expectations scale with B.
module tb_midi_tx;
  import midi_pkg::*;

  localparam int B      = 16;
  localparam int TB_CLK = MIDI_BAUD * B;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0][23:0] msg;
  logic [1:0]      valid;
  logic [1:0]      ready;
  logic [1:0]      line;
  logic [1:0]      busy;
  logic [1:0]      done;
  logic [1:0][1:0] dbg;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_last [2];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [23:0] m;
    int          inst;
    int          exp_n;
  } vec_t;

  vec_t vecs [21];

  midi_tx #(.CLK_HZ(TB_CLK), .BAUD(MIDI_BAUD), .RUNNING_STATUS(1)) dut_rs (
    .Clk(clk), .Rst_p(rst), .Msg(msg[0]), .MsgValid(valid[0]), .MsgReady(ready[0]),
    .MIDI_out(line[0]), .Busy(busy[0]), .Done(done[0]), .DbgState(dbg[0])
  );

  midi_tx #(.CLK_HZ(TB_CLK), .BAUD(MIDI_BAUD), .RUNNING_STATUS(0)) dut_nors (
    .Clk(clk), .Rst_p(rst), .Msg(msg[1]), .MsgValid(valid[1]), .MsgReady(ready[1]),
    .MIDI_out(line[1]), .Busy(busy[1]), .Done(done[1]), .DbgState(dbg[1])
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish within 200000 cycles");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: bytes on the wire for message m, from the MIDI rules.
  task automatic model_msg(input int inst, input logic [23:0] m);
    logic [7:0] s;
    bit         rs;
    s  = m[23:16];
    rs = (inst == 0);
    exp_q.delete();
    if (s < 8'h80) return;
    if (s >= 8'hF0) begin
      exp_q.push_back(s);
      if (rs && s < 8'hF8) model_last[inst] = 8'h00;
      return;
    end
    if (!(rs && s == model_last[inst])) exp_q.push_back(s);
    exp_q.push_back(m[15:8]);
    if (!(s >= 8'hC0 && s <= 8'hDF)) exp_q.push_back(m[7:0]);
    if (rs) model_last[inst] = s;
  endtask

  // Offer m on instance inst, then check every cycle of the resulting frame
  // and the Done cycle. exp_n < 0 takes the byte count from the model.
  // hold_next keeps MsgValid high with next_m during the frame and returns in
  // the Done cycle; expect_now requires acceptance without any wait.
  // Called and returns at a negedge.
  task automatic xfer(input int inst, input logic [23:0] m, input int exp_n,
                      input bit hold_next, input logic [23:0] next_m, input bit expect_now);
    int   waited;
    int   n;
    int   total_c;
    int   byte_bad;
    int   side_bad;
    int   p, i, j;
    logic exp_bit;
    waited     = 0;
    msg[inst]  = m;
    valid[inst] = 1'b1;
    while (!ready[inst] && waited < 4000) begin
      @(negedge clk);
      waited++;
    end
    if (!ready[inst]) begin
      check("accept_timeout", 32'(waited), 32'd0);
      valid[inst] = 1'b0;
      return;
    end
    if (expect_now) check("accept_in_done_cycle", 32'(waited), 32'd0);
    model_msg(inst, m);
    n       = (exp_n < 0) ? exp_q.size() : exp_n;
    total_c = (n == 0) ? 1 : n * 10 * B + 1;
    @(negedge clk);  // c = 1: first cycle after the accept edge
    if (hold_next) msg[inst] = next_m;
    else valid[inst] = 1'b0;
    if (n > 0) begin
      check("start_bit_falls", 32'(line[inst]), 32'd0);
      check("busy_after_accept", 32'(busy[inst]), 32'd1);
      check("ready_low_after_accept", 32'(ready[inst]), 32'd0);
    end
    byte_bad = 0;
    side_bad = 0;
    for (int c = 1; c < total_c; c++) begin
      p = (c - 1) / B;
      i = p / 10;
      j = p % 10;
      if (j == 0) exp_bit = 1'b0;
      else if (j == 9) exp_bit = 1'b1;
      else if (i < exp_q.size()) exp_bit = exp_q[i][j-1];
      else exp_bit = 1'b1;
      if (line[inst] !== exp_bit) byte_bad++;
      if (busy[inst] !== 1'b1 || done[inst] !== 1'b0 || ready[inst] !== 1'b0) side_bad++;
      if ((c % (10 * B)) == 0) begin
        check($sformatf("frame_byte%0d_inst%0d_msg%06h_badcycles", i, inst, m), 32'(byte_bad), 32'd0);
        byte_bad = 0;
      end
      @(negedge clk);
    end
    if (n > 0) check("busy_ready_during_frame_badcycles", 32'(side_bad), 32'd0);
    check($sformatf("done_at_end_inst%0d_msg%06h", inst, m), 32'(done[inst]), 32'd1);
    check("ready_in_done_cycle", 32'(ready[inst]), 32'd1);
    check("busy_low_in_done_cycle", 32'(busy[inst]), 32'd0);
    check("line_idle_in_done_cycle", 32'(line[inst]), 32'd1);
    check("state_idle_in_done_cycle", 32'(dbg[inst]), 32'(ST_IDLE));
    if (!hold_next) begin
      @(negedge clk);
      check("done_one_cycle", 32'(done[inst]), 32'd0);
    end
  endtask

  initial begin
    // clock/reset
    rst   = 1'b1;
    msg   = '0;
    valid = '0;
    model_last[0] = 8'h00;
    model_last[1] = 8'h00;

    // vector table: {message, instance, bytes on the wire}
    vecs[0]  = '{24'h903C64, 0, 3};
    vecs[1]  = '{24'h903C00, 0, 2};
    vecs[2]  = '{24'hC50700, 0, 2};
    vecs[3]  = '{24'hC50800, 0, 1};
    vecs[4]  = '{24'hF81234, 0, 1};
    vecs[5]  = '{24'hC50900, 0, 1};
    vecs[6]  = '{24'h903C64, 0, 3};
    vecs[7]  = '{24'hF81234, 0, 1};
    vecs[8]  = '{24'h903C64, 0, 2};
    vecs[9]  = '{24'hF0AAAA, 0, 1};
    vecs[10] = '{24'h903C64, 0, 3};
    vecs[11] = '{24'h3C4000, 0, 0};
    vecs[12] = '{24'h903C64, 0, 2};
    vecs[13] = '{24'hE01234, 0, 3};
    vecs[14] = '{24'hBF7F00, 0, 3};
    vecs[15] = '{24'hDF5500, 0, 2};
    vecs[16] = '{24'h903C64, 1, 3};
    vecs[17] = '{24'h903C00, 1, 3};
    vecs[18] = '{24'hC50700, 1, 2};
    vecs[19] = '{24'h00FFFF, 1, 0};
    vecs[20] = '{24'hFF0000, 1, 1};

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check("reset_line_high", 32'(line[k]), 32'd1);
      check("reset_ready", 32'(ready[k]), 32'd1);
      check("reset_busy", 32'(busy[k]), 32'd0);
      check("reset_done", 32'(done[k]), 32'd0);
      check("reset_state", 32'(dbg[k]), 32'(ST_IDLE));
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_line_after_release", 32'(line[0]), 32'd1);

    // table-driven vectors
    for (int k = 0; k < 21; k++) begin
      xfer(vecs[k].inst, vecs[k].m, vecs[k].exp_n, 1'b0, 24'h0, 1'b0);
    end

    // back-pressure: second message held during the first frame
    xfer(0, 24'h913C64, 3, 1'b1, 24'h804000, 1'b0);
    xfer(0, 24'h804000, 3, 1'b0, 24'h0, 1'b1);

    // reset during data bit 3 of a status byte 0x90
    xfer(0, 24'hF00000, 1, 1'b0, 24'h0, 1'b0);
    msg[0]   = 24'h903C64;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (4 * B + B / 2 - 1) @(negedge clk);
    check("line_in_data_bit3", 32'(line[0]), 32'd0);
    check("busy_before_reset", 32'(busy[0]), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("reset_midframe_line", 32'(line[0]), 32'd1);
    check("reset_midframe_ready", 32'(ready[0]), 32'd1);
    check("reset_midframe_busy", 32'(busy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_last[0] = 8'h00;
    model_last[1] = 8'h00;
    @(negedge clk);
    xfer(0, 24'h903C64, 3, 1'b0, 24'h0, 1'b0);

    // randomized messages against the reference model
    for (int k = 0; k < 40; k++) begin
      int          inst;
      logic [7:0]  s;
      logic [23:0] m;
      inst = $urandom_range(0, 1);
      case ($urandom_range(0, 5))
        0:       s = 8'h90 + 8'($urandom_range(0, 1));
        1:       s = 8'hC0;
        2:       s = 8'hF8 + 8'($urandom_range(0, 7));
        3:       s = 8'hF0 + 8'($urandom_range(0, 7));
        4:       s = 8'($urandom_range(0, 255));
        default: s = 8'hE0;
      endcase
      m = {s, 16'($urandom_range(0, 65535))};
      xfer(inst, m, -1, 1'b0, 24'h0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
